// File: rtl/ham_encoder_stream.sv
// ham_encoder_stream: streaming Hamming(7,4) encoder with a 2-entry output buffer,
// optional single-bit error injection and delivered/injected word counters.
module ham_encoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [2:0]       inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_code,
    output logic             out_inj,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] inj_cnt
);
    logic [7:0] mem [2];
    logic [7:0] last;
    logic [1:0] occ;
    logic       wr_ptr, rd_ptr, live;
    logic [6:0] code, flip;
    logic       push, pop;

    always_comb begin
        code = {in_data[3], in_data[2], in_data[1], in_data[1] ^ in_data[2] ^ in_data[3],
                in_data[0], in_data[0] ^ in_data[2] ^ in_data[3], in_data[0] ^ in_data[1] ^ in_data[3]};
        flip = (inj_pos == 3'd0) ? 7'd0 : 7'd1 << (inj_pos - 3'd1);
    end

    // live holds in_ready low until the first clock after reset release
    assign in_ready  = live && occ != 2'd2;
    assign out_valid = occ != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {out_inj, out_code} = out_valid ? mem[rd_ptr] : last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            last     <= '0;
            occ      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            live     <= 1'b0;
            word_cnt <= '0;
            inj_cnt  <= '0;
        end else begin
            live <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= {inj_pos != 3'd0, code ^ flip};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                last   <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
            if (clr_cnt) begin
                word_cnt <= '0;
                inj_cnt  <= '0;
            end else if (pop) begin
                word_cnt <= word_cnt + CNT_W'(1);
                inj_cnt  <= inj_cnt + CNT_W'(mem[rd_ptr][7]);
            end
        end
    end
endmodule
